decode_issue: RTL and testbench

- Decode/issue stage directly upstream of the 16-bit ALU.
- Accepts 16-bit instructions over a valid/ready handshake and reads an internal 8x16 register file.
- Stalls on register hazards using a pending-write scoreboard.
- Presents a registered operand bundle (a, b, alu_op plus memory/branch controls) to the execute stage; writeback results return through a dedicated write port.

---
 rtl/rv16_pkg.sv | 45 ++++
 rtl/regfile_8x16.sv | 36 +++
 rtl/decode_issue.sv | 148 ++++++++++++++
 tb/tb_decode_issue.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rv16_pkg.sv
// Shared ISA definitions for the rv16 datapath: opcodes, ALU codes,
// instruction field positions and the issue bundle handed to execute.
package rv16_pkg;

  localparam int XLEN = 16;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_SLL = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  localparam int OP_LSB  = 12;
  localparam int RS_LSB  = 9;
  localparam int RT_LSB  = 6;
  localparam int RD_LSB  = 3;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 6;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [1:0]      alu_op;
    logic [2:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [XLEN-1:0] store_data;
    logic            branch;
    logic [XLEN-1:0] br_offset;
  } issue_bundle_t;

  function automatic logic [XLEN-1:0] sext_imm6(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/regfile_8x16.sv
// Eight-entry register file: two combinational read ports, one synchronous
// write port, r0 hardwired to zero, same-cycle write data forwarded to reads.
module regfile_8x16
  import rv16_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [2:0]      raddr_b,
  output logic [XLEN-1:0] rdata_b,
  input  logic            we,
  input  logic [2:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (we && waddr != 3'd0) begin
      regs[waddr] <= wdata;
    end
  end

  // Forwarding the writeback lets a stalled consumer issue in the same cycle
  // its producer's result arrives.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (raddr_a != 3'd0) rdata_a = (we && waddr == raddr_a) ? wdata : regs[raddr_a];
    if (raddr_b != 3'd0) rdata_b = (we && waddr == raddr_b) ? wdata : regs[raddr_b];
  end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage feeding the 16-bit ALU: decodes, reads operands, tracks
// pending register writes and stalls on hazards before issuing a bundle.
module decode_issue
  import rv16_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [15:0]            in_instr,
  output logic                   in_ready,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [DATA_W-1:0]      ex_a,
  output logic [DATA_W-1:0]      ex_b,
  output logic [1:0]             ex_alu_op,
  output logic [2:0]             ex_rd,
  output logic                   ex_reg_write,
  output logic                   ex_mem_read,
  output logic                   ex_mem_write,
  output logic [DATA_W-1:0]      ex_store_data,
  output logic                   ex_branch,
  output logic [DATA_W-1:0]      ex_br_offset,
  input  logic                   wb_en,
  input  logic [2:0]             wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   flush,
  output logic                   illegal,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [3:0]       op;
  logic [2:0]       rs, rt, rd_field;
  logic [XLEN-1:0]  imm_sext;
  logic [XLEN-1:0]  rs_val, rt_val;
  logic             legal, is_rtype, uses_rt, writes;
  logic [2:0]       dest;
  logic [7:0]       busy_q, busy_eff, busy_d;
  logic             hazard, fire;
  issue_bundle_t    dec, bundle_q;
  logic             ex_valid_q, illegal_q;
  logic [STALL_CNT_W-1:0] stall_q;

  assign op       = in_instr[OP_LSB +: 4];
  assign rs       = in_instr[RS_LSB +: 3];
  assign rt       = in_instr[RT_LSB +: 3];
  assign rd_field = in_instr[RD_LSB +: 3];
  assign imm_sext = sext_imm6(in_instr[IMM_LSB +: IMM_W]);

  regfile_8x16 u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (rs),
    .rdata_a (rs_val),
    .raddr_b (rt),
    .rdata_b (rt_val),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data)
  );

  assign legal    = ~op[3];
  assign is_rtype = ~op[3] & ~op[2];
  assign uses_rt  = is_rtype | (op == OP_SW) | (op == OP_BEQ);
  assign writes   = is_rtype | (op == OP_ADDI) | (op == OP_LW);
  assign dest     = is_rtype ? rd_field : rt;

  always_comb begin
    dec           = '0;
    dec.a         = rs_val;
    dec.b         = rt_val;
    dec.alu_op    = ALU_ADD;
    dec.rd        = writes ? dest : 3'd0;
    dec.reg_write = writes;
    case (op)
      OP_ADD:  dec.alu_op = ALU_ADD;
      OP_SUB:  dec.alu_op = ALU_SUB;
      OP_SLL:  dec.alu_op = ALU_SLL;
      OP_AND:  dec.alu_op = ALU_AND;
      OP_ADDI: dec.b = imm_sext;
      OP_LW: begin
        dec.b        = imm_sext;
        dec.mem_read = 1'b1;
      end
      OP_SW: begin
        dec.b          = imm_sext;
        dec.mem_write  = 1'b1;
        dec.store_data = rt_val;
      end
      OP_BEQ: begin
        dec.alu_op    = ALU_SUB;
        dec.branch    = 1'b1;
        dec.br_offset = imm_sext;
      end
      default: dec = '0;
    endcase
  end

  // The hazard check sees this cycle's writeback clear already applied;
  // r0 stays free because its busy bit is forced low every cycle.
  always_comb begin
    busy_eff = busy_q;
    if (wb_en) busy_eff[wb_addr] = 1'b0;
    hazard = legal & (busy_eff[rs] | (uses_rt & busy_eff[rt]) | (writes & busy_eff[dest]));
    in_ready = rst_n & (~ex_valid_q | ex_ready) & ~hazard & ~flush;
    fire = in_valid & in_ready;
    busy_d = busy_eff;
    if (flush && ex_valid_q && bundle_q.reg_write && !ex_ready) busy_d[bundle_q.rd] = 1'b0;
    if (fire && writes) busy_d[dest] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      bundle_q   <= '0;
      illegal_q  <= 1'b0;
      busy_q     <= '0;
      stall_q    <= '0;
    end else begin
      busy_q    <= busy_d;
      illegal_q <= fire & ~legal;
      if (flush)         ex_valid_q <= 1'b0;
      else if (fire)     ex_valid_q <= legal;
      else if (ex_ready) ex_valid_q <= 1'b0;
      if (fire && legal) bundle_q <= dec;
      if (in_valid && hazard && !flush && stall_q != {STALL_CNT_W{1'b1}})
        stall_q <= stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_a          = bundle_q.a;
  assign ex_b          = bundle_q.b;
  assign ex_alu_op     = bundle_q.alu_op;
  assign ex_rd         = bundle_q.rd;
  assign ex_reg_write  = bundle_q.reg_write;
  assign ex_mem_read   = bundle_q.mem_read;
  assign ex_mem_write  = bundle_q.mem_write;
  assign ex_store_data = bundle_q.store_data;
  assign ex_branch     = bundle_q.branch;
  assign ex_br_offset  = bundle_q.br_offset;
  assign illegal       = illegal_q;
  assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_decode_issue.sv
// Scoreboard bench for decode_issue: expected bundles are queued when an
// instruction is consumed and compared when execute accepts the bundle.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, ex_valid, ex_ready;
  logic [15:0] in_instr;
  logic [15:0] ex_a, ex_b, ex_store_data, ex_br_offset, wb_data;
  logic [1:0]  ex_alu_op;
  logic [2:0]  ex_rd, wb_addr;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
  logic        wb_en, flush, illegal;
  logic [15:0] stall_cnt;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  alu_op;
    logic [2:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [15:0] sd;
    logic        br;
    logic [15:0] bo;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        got_e;
  logic [15:0] model_rf [8];
  int          checks = 0;
  int          errors = 0;

  decode_issue #(.DATA_W(16), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_a(ex_a), .ex_b(ex_b), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data),
    .ex_branch(ex_branch), .ex_br_offset(ex_br_offset), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .illegal(illegal),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] instr, input logic exr,
                               input logic fl, input logic we, input logic [2:0] wa,
                               input logic [15:0] wd);
    @(posedge clk);
    #1;
    in_valid = v;
    in_instr = instr;
    ex_ready = exr;
    flush    = fl;
    wb_en    = we;
    wb_addr  = wa;
    wb_data  = wd;
    @(negedge clk);
  endtask

  function automatic logic [15:0] readModel(input logic [2:0] r);
    if (r == 3'd0) return 16'h0;
    if (wb_en && wb_addr == r) return wb_data;
    return model_rf[r];
  endfunction

  function automatic exp_t expectFor(input logic [15:0] instr);
    exp_t        e;
    logic [15:0] imm_x;
    e     = '0;
    imm_x = {{10{instr[5]}}, instr[5:0]};
    e.a   = readModel(instr[11:9]);
    case (instr[15:12])
      4'd0, 4'd1, 4'd2, 4'd3: begin
        e.b = readModel(instr[8:6]); e.alu_op = instr[13:12]; e.rd = instr[5:3]; e.rw = 1'b1;
      end
      4'd4: begin e.b = imm_x; e.rd = instr[8:6]; e.rw = 1'b1; end
      4'd5: begin e.b = imm_x; e.rd = instr[8:6]; e.rw = 1'b1; e.mr = 1'b1; end
      4'd6: begin e.b = imm_x; e.mw = 1'b1; e.sd = readModel(instr[8:6]); end
      4'd7: begin e.b = readModel(instr[8:6]); e.alu_op = 2'b01; e.br = 1'b1; e.bo = imm_x; end
      default: e = '0;
    endcase
    return e;
  endfunction

  // Accepted bundles are compared in order; a flushed, unaccepted bundle is dropped.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < 8; i++) model_rf[i] = 16'h0;
    end else begin
      if (ex_valid && ex_ready) begin
        checkOutput("bundle_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          got_e = exp_q.pop_front();
          checkOutput("ex_a", 32'(ex_a), 32'(got_e.a));
          checkOutput("ex_b", 32'(ex_b), 32'(got_e.b));
          checkOutput("ex_ctrl",
                      32'({ex_alu_op, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}),
                      32'({got_e.alu_op, got_e.rd, got_e.rw, got_e.mr, got_e.mw, got_e.br}));
          checkOutput("ex_store_data", 32'(ex_store_data), 32'(got_e.sd));
          checkOutput("ex_br_offset", 32'(ex_br_offset), 32'(got_e.bo));
        end
      end else if (ex_valid && flush) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready && !in_instr[15]) exp_q.push_back(expectFor(in_instr));
      if (wb_en && wb_addr != 3'd0) model_rf[wb_addr] = wb_data;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    in_valid = 1'b0; in_instr = 16'h0; ex_ready = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = 3'd0; wb_data = 16'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_illegal", 32'(illegal), 32'd0);
    checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("rst_ex_a", 32'(ex_a), 32'd0);
    #2 rst_n = 1'b1;

    // r1=5, r2=3, then add r3,r1,r2
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd1, 16'd5);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd2, 16'd3);
    applyStimulus(1'b1, 16'h0298, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    checkOutput("add_in_ready", 32'(in_ready), 32'd1);

    // addi r3,r3,-1 stalls on busy r3 until its writeback arrives
    applyStimulus(1'b1, 16'h46FF, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    checkOutput("haz_in_ready0", 32'(in_ready), 32'd0);
    checkOutput("add_ex_valid", 32'(ex_valid), 32'd1);
    checkOutput("stall_cnt0", 32'(stall_cnt), 32'd0);
    applyStimulus(1'b1, 16'h46FF, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    checkOutput("haz_in_ready1", 32'(in_ready), 32'd0);
    checkOutput("stall_cnt1", 32'(stall_cnt), 32'd1);
    checkOutput("drained_ex_valid", 32'(ex_valid), 32'd0);
    applyStimulus(1'b1, 16'h46FF, 1'b1, 1'b0, 1'b1, 3'd3, 16'd8);
    checkOutput("wb_release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("stall_cnt2", 32'(stall_cnt), 32'd2);

    // backpressure: addi bundle must hold while sub r6,r1,r2 waits
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    applyStimulus(1'b1, 16'h12B0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    checkOutput("bp_hold_a", 32'(ex_a), 32'h8);
    checkOutput("bp_hold_b", 32'(ex_b), 32'hFFFF);
    applyStimulus(1'b1, 16'h12B0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);

    // lw r5,2(r1) then flush before acceptance; add r7,r1,r2 must not be consumed
    applyStimulus(1'b1, 16'h5342, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    applyStimulus(1'b1, 16'h02B8, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
    checkOutput("flush_ex_valid_before", 32'(ex_valid), 32'd1);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    checkOutput("flush_ex_valid_after", 32'(ex_valid), 32'd0);
    applyStimulus(1'b1, 16'h0A78, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    checkOutput("flush_r5_free", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);

    // undefined opcode
    applyStimulus(1'b1, 16'hF000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    checkOutput("illegal_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    checkOutput("illegal_pulse", 32'(illegal), 32'd1);
    checkOutput("illegal_no_bundle", 32'(ex_valid), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    checkOutput("illegal_one_cycle", 32'(illegal), 32'd0);

    // r3 still busy (issue set beat the writeback clear); reset mid-stall
    applyStimulus(1'b1, 16'h0608, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    checkOutput("r3_busy_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 16'h0608, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    checkOutput("stall_cnt3", 32'(stall_cnt), 32'd3);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("async_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("async_rst_ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("async_rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    applyStimulus(1'b1, 16'h0608, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    checkOutput("post_rst_busy_clear", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 16'h0480, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    checkOutput("add_r0_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    checkOutput("r0_never_busy", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
